// File: rtl/digit_roller_n_if.sv
// digit_roller_n_if: control, memory-write and display bundle for digit_roller_n.
// The bounce signal exists only when ROLLER_BOUNCE_EN is defined.
interface digit_roller_n_if #(
    parameter int NUM_DIGITS = 4,
    parameter int SEQ_LEN    = 12,
    parameter int DIV_WIDTH  = 8
);
    localparam int AW = $clog2(SEQ_LEN);
    logic                    en;
    logic                    sel;
    logic                    dir;
    logic [DIV_WIDTH-1:0]    step_div;
    logic                    wr_en;
    logic                    wr_bank;
    logic [AW-1:0]           wr_addr;
    logic [3:0]              wr_data;
    logic [4*NUM_DIGITS-1:0] digits;
    logic                    wrap;
`ifdef ROLLER_BOUNCE_EN
    logic                    bounce;
`endif
    modport master (
`ifdef ROLLER_BOUNCE_EN
        output bounce,
`endif
        output en, sel, dir, step_div, wr_en, wr_bank, wr_addr, wr_data,
        input  digits, wrap
    );
    modport slave (
`ifdef ROLLER_BOUNCE_EN
        input  bounce,
`endif
        input  en, sel, dir, step_div, wr_en, wr_bank, wr_addr, wr_data,
        output digits, wrap
    );
endinterface

// File: rtl/digit_roller_n.sv
// digit_roller_n: scrolls an N-digit window over one of two writable digit banks.
// Define ROLLER_BOUNCE_EN to add ping-pong (bounce) scrolling between 0 and SEQ_LEN-NUM_DIGITS.
module digit_roller_n #(
    parameter int NUM_DIGITS = 4,
    parameter int SEQ_LEN    = 12,
    parameter int DIV_WIDTH  = 8
) (
    input logic clk,
    input logic rst_n,
    digit_roller_n_if.slave bus
);
    localparam int AW = $clog2(SEQ_LEN);
    localparam logic [AW-1:0] LAST = AW'(SEQ_LEN - 1);
    logic [3:0]              mem_a [SEQ_LEN];
    logic [3:0]              mem_b [SEQ_LEN];
    logic [DIV_WIDTH-1:0]    div_cnt;
    logic [AW-1:0]           head, head_n;
    logic                    wrap_n, tick;
    logic [4*NUM_DIGITS-1:0] digits_n;
    assign tick = bus.en && div_cnt == bus.step_div;
`ifdef ROLLER_BOUNCE_EN
    localparam logic [AW-1:0] LIM = AW'(SEQ_LEN - NUM_DIGITS);
    logic bdir, bdir_n;
`endif
    always_comb begin
        head_n = head;
        wrap_n = 1'b0;
`ifdef ROLLER_BOUNCE_EN
        bdir_n = bdir;
        if (bus.bounce) begin
            if (LIM == '0) head_n = '0;
            else if (head > LIM) head_n = LIM;
            else if (!bdir) begin
                head_n = head == LIM ? LIM - 1'b1 : head + 1'b1;
                bdir_n = head == LIM;
                wrap_n = head == LIM;
            end else begin
                head_n = head == '0 ? AW'(1) : head - 1'b1;
                bdir_n = head != '0;
                wrap_n = head == '0;
            end
        end else begin
`else
        begin
`endif
            head_n = bus.dir ? (head == '0 ? LAST : head - 1'b1) : (head == LAST ? '0 : head + 1'b1);
            wrap_n = bus.dir ? head == '0 : head == LAST;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            head     <= '0;
            bus.wrap <= 1'b0;
`ifdef ROLLER_BOUNCE_EN
            bdir     <= 1'b0;
`endif
        end else begin
            div_cnt  <= tick ? '0 : bus.en ? div_cnt + 1'b1 : div_cnt;
            bus.wrap <= tick && wrap_n;
            if (tick) begin
                head <= head_n;
`ifdef ROLLER_BOUNCE_EN
                bdir <= bdir_n;
`endif
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SEQ_LEN; k++) begin
                mem_a[k] <= 4'(k % 10);
                mem_b[k] <= 4'(9 - k % 10);
            end
        end else if (bus.wr_en && {1'b0, bus.wr_addr} < (AW + 1)'(SEQ_LEN)) begin
            if (bus.wr_bank) mem_b[bus.wr_addr] <= bus.wr_data;
            else mem_a[bus.wr_addr] <= bus.wr_data;
        end
    end
    // head+i stays below 2*SEQ_LEN, so one conditional subtract gives the modulo
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        logic [AW:0] sum, idx;
        assign sum = {1'b0, head} + (AW + 1)'(i);
        assign idx = sum >= (AW + 1)'(SEQ_LEN) ? sum - (AW + 1)'(SEQ_LEN) : sum;
        assign digits_n[4*i +: 4] = bus.sel ? mem_b[idx[AW-1:0]] : mem_a[idx[AW-1:0]];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.digits <= '0;
        else bus.digits <= digits_n;
    end
endmodule

// File: tb/tb_digit_roller_n.sv
// tb_digit_roller_n: directed and random stimulus against an arithmetic model of the roller.
module tb_digit_roller_n;
    localparam int N  = 4;
    localparam int L  = 12;
    localparam int DW = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;
    int   ma [L];
    int   mb [L];
    int   m_head, m_div;
    logic [4*N-1:0] m_dig;
    logic           m_wrap;
    digit_roller_n_if #(.NUM_DIGITS(N), .SEQ_LEN(L), .DIV_WIDTH(DW)) bif ();
    digit_roller_n #(.NUM_DIGITS(N), .SEQ_LEN(L), .DIV_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bif)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask
    task automatic model_reset();
        for (int k = 0; k < L; k++) begin
            ma[k] = k % 10;
            mb[k] = 9 - k % 10;
        end
        m_head = 0;
        m_div  = 0;
        m_dig  = '0;
        m_wrap = 1'b0;
    endtask
    task automatic model_edge();
        int tick;
        for (int i = 0; i < N; i++)
            m_dig[4*i +: 4] = 4'(bif.sel ? mb[(m_head + i) % L] : ma[(m_head + i) % L]);
        if (bif.wr_en && int'(bif.wr_addr) < L) begin
            if (bif.wr_bank) mb[bif.wr_addr] = int'(bif.wr_data);
            else ma[bif.wr_addr] = int'(bif.wr_data);
        end
        tick = bif.en && m_div == int'(bif.step_div);
        if (bif.en) m_div = tick ? 0 : (m_div + 1) % (1 << DW);
        m_wrap = 1'b0;
        if (tick) begin
            m_wrap = bif.dir ? m_head == 0 : m_head == L - 1;
            m_head = bif.dir ? (m_head + L - 1) % L : (m_head + 1) % L;
        end
    endtask
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, ".digits"}, 32'(bif.digits), 32'(m_dig));
        chk({tag, ".wrap"}, 32'(bif.wrap), 32'(m_wrap));
    endtask
    initial begin
        bif.en = 0; bif.sel = 0; bif.dir = 0; bif.step_div = '0;
        bif.wr_en = 0; bif.wr_bank = 0; bif.wr_addr = '0; bif.wr_data = '0;
`ifdef ROLLER_BOUNCE_EN
        bif.bounce = 0;
`endif
        model_reset();
        #12;
        chk("reset.digits", 32'(bif.digits), 32'h0);
        chk("reset.wrap", 32'(bif.wrap), 32'h0);
        @(negedge clk);
        rst_n = 1;
        bif.en = 1;
        step("fwd0");
        chk("fwd_first", 32'(bif.digits), 32'h3210);
        for (int c = 0; c < 28; c++) step("fwd");
        bif.dir = 1;
        for (int c = 0; c < 6; c++) step("rev");
        bif.dir = 0;
        bif.step_div = 3;
        for (int c = 0; c < 20; c++) step("pre");
        bif.en = 0;
        for (int c = 0; c < 10; c++) step("hold");
        bif.en = 1;
        for (int c = 0; c < 10; c++) step("resume");
        bif.sel = 1;
        bif.wr_en = 1; bif.wr_bank = 1; bif.wr_addr = 5; bif.wr_data = 4'hE;
        step("wr");
        bif.wr_addr = 13; bif.wr_data = 4'h7;
        step("wr_oob");
        bif.wr_en = 0;
        for (int c = 0; c < 16; c++) step("bank_b");
        for (int c = 0; c < 400; c++) begin
            bif.en       = $urandom_range(0, 7) != 0;
            bif.sel      = 1'($urandom);
            bif.dir      = 1'($urandom);
            bif.step_div = DW'($urandom_range(0, 3));
            bif.wr_en    = $urandom_range(0, 3) == 0;
            bif.wr_bank  = 1'($urandom);
            bif.wr_addr  = 4'($urandom_range(0, 15));
            bif.wr_data  = 4'($urandom);
            step("rand");
        end
        bif.wr_en = 0; bif.en = 1; bif.step_div = 0; bif.dir = 0; bif.sel = 1;
        for (int c = 0; c < 5; c++) step("pre_rst");
        #1 rst_n = 0;
        #1;
        chk("midrst.digits", 32'(bif.digits), 32'h0);
        chk("midrst.wrap", 32'(bif.wrap), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 14; c++) step("post_rst");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
